// File: rtl/x_inject_sched_pkg.sv
// Shared types, defaults and sizing helper for the DFFx fault-injection controllers.
package xprova_inj_pkg;

  typedef enum logic [2:0] {IDLE, ARB, HOLD, COOL, EXH} state_t;

  localparam int DEF_N        = 4;
  localparam int DEF_MAX_INJ  = 3;
  localparam int DEF_HOLD_CYC = 1;
  localparam int DEF_COOL_CYC = 0;

  // Bits needed to hold values 0..v-1; never returns less than one.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/x_inject_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after i_ptr, cyclically.
// Zero latency; o_gnt_vld is low when no request is set.
module rr_arbiter
  import xprova_inj_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int IW = clog2(DEF_N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_gnt_idx,
  output logic          o_gnt_vld
);

  logic [IW-1:0] w_idx;

  always_comb begin
    o_gnt_idx = '0;
    o_gnt_vld = 1'b0;
    w_idx     = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = IW'((int'(i_ptr) + k) % N);
      if (!o_gnt_vld && i_req[w_idx]) begin
        o_gnt_vld = 1'b1;
        o_gnt_idx = w_idx;
      end
    end
  end

endmodule

// File: rtl/x_inject_sched.sv
// Schedules bounded fault injections into a bank of DFFx flops, one flop at a time, round-robin.
// Registered outputs; V rises one cycle after an ARB grant and holds HOLD_CYC cycles.
module x_inject_sched
  import xprova_inj_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int MAX_INJ  = DEF_MAX_INJ,
  parameter int HOLD_CYC = DEF_HOLD_CYC,
  parameter int COOL_CYC = DEF_COOL_CYC,
  parameter int CW       = clog2(MAX_INJ + 1),
  parameter int IW       = clog2(N)
) (
  input  logic          CK,
  input  logic          RS,
  input  logic          en,
  input  logic          clr,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  rnd_d,
  input  logic [N-1:0]  rnd_v,
  output logic [N-1:0]  V,
  output logic [N-1:0]  rD,
  output logic [N-1:0]  rV,
  output logic [IW-1:0] grant_idx,
  output logic [CW-1:0] inj_cnt,
  output logic          exhausted
);

  localparam int TW = clog2(((HOLD_CYC > COOL_CYC) ? HOLD_CYC : COOL_CYC) + 1);

  state_t        r_state, w_nxt;
  logic [TW-1:0] r_cnt, w_cnt_nxt;
  logic [IW-1:0] r_ptr, w_ptr_nxt, r_gidx, w_gidx_nxt;
  logic [CW-1:0] r_inj, w_inj_nxt;
  logic [N-1:0]  r_v, r_rd, r_rv, w_sel;
  logic          r_exh;
  logic [IW-1:0] w_arb_idx;
  logic          w_arb_vld;
  logic          w_budget, w_last, w_cnt_last;

  rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .i_req     (req),
    .i_ptr     (r_ptr),
    .o_gnt_idx (w_arb_idx),
    .o_gnt_vld (w_arb_vld)
  );

  assign w_budget   = (int'(r_inj) < MAX_INJ);
  assign w_last     = (int'(r_inj) + 1 >= MAX_INJ);
  assign w_cnt_last = (r_cnt == TW'(1));

  always_ff @(posedge CK or negedge RS) begin
    if (!RS) r_state <= IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    if (clr || !en) begin
      w_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: w_nxt = ARB;
        ARB: begin
          if (!w_budget)      w_nxt = EXH;
          else if (w_arb_vld) w_nxt = HOLD;
        end
        HOLD: begin
          if (w_cnt_last) begin
            if (w_last)            w_nxt = EXH;
            else if (COOL_CYC > 0) w_nxt = COOL;
            else                   w_nxt = ARB;
          end
        end
        COOL:    if (w_cnt_last) w_nxt = ARB;
        default: w_nxt = r_state;
      endcase
    end
  end

  // An aborted hold (en low) leaves budget and pointer untouched.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_ptr_nxt  = r_ptr;
    w_gidx_nxt = r_gidx;
    w_inj_nxt  = r_inj;
    w_sel      = '0;
    if (clr) begin
      w_inj_nxt = '0;
      w_ptr_nxt = '0;
    end else if (en) begin
      case (r_state)
        ARB: begin
          if (w_budget && w_arb_vld) begin
            w_gidx_nxt = w_arb_idx;
            w_cnt_nxt  = TW'(HOLD_CYC);
            w_sel      = N'(1) << w_arb_idx;
          end
        end
        HOLD: begin
          if (w_cnt_last) begin
            if (w_budget) w_inj_nxt = r_inj + CW'(1);
            w_ptr_nxt = IW'((int'(r_gidx) + 1) % N);
            w_cnt_nxt = TW'(COOL_CYC);
          end else begin
            w_cnt_nxt = r_cnt - TW'(1);
            w_sel     = N'(1) << r_gidx;
          end
        end
        COOL:    w_cnt_nxt = r_cnt - TW'(1);
        default: w_cnt_nxt = r_cnt;
      endcase
    end
  end

  always_ff @(posedge CK or negedge RS) begin
    if (!RS) begin
      r_cnt  <= '0;
      r_ptr  <= '0;
      r_gidx <= '0;
      r_inj  <= '0;
      r_v    <= '0;
      r_rd   <= '0;
      r_rv   <= '0;
      r_exh  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_ptr  <= w_ptr_nxt;
      r_gidx <= w_gidx_nxt;
      r_inj  <= w_inj_nxt;
      r_v    <= w_sel;
      r_rd   <= w_sel & rnd_d;
      r_rv   <= w_sel & rnd_v;
      r_exh  <= (w_nxt == EXH);
    end
  end

  assign V         = r_v;
  assign rD        = r_rd;
  assign rV        = r_rv;
  assign grant_idx = r_gidx;
  assign inj_cnt   = r_inj;
  assign exhausted = r_exh;

endmodule

// File: doc/x_inject_sched.md
Name: x_inject_sched

Overview:
- Sequences fault injection into a bank of N DFFx instrumented flops during formal runs.
- Drives each flop's V (violation select), rD (replacement data) and rV (metastable mark).
- Grants at most one flop per injection, chosen round-robin among eligible flops.
- Enforces a hold length, a cool-down gap and a total injection budget, so violation scenarios stay bounded and reproducible.

Parameters:
- N, 4: number of DFFx instances served.
- MAX_INJ, 3: injections allowed before exhaustion.
- HOLD_CYC, 1: cycles V stays asserted per injection (≥1).
- COOL_CYC, 0: idle cycles between consecutive injections.
- CW, clog2(MAX_INJ+1): injection counter width.
- IW, clog2(N) (minimum 1): grant index width.

Ports:
- CK  in  1  clock.
- RS  in  1  reset; asynchronous, active-low.
- en  in  1  scheduler enable.
- clr  in  1  synchronous restart: clears budget and pointer.
- req  in  N  req[i]=1 means flop i is eligible (its D differs from Q).
- rnd_d  in  N  free nondeterministic data bits.
- rnd_v  in  N  free nondeterministic metastable-mark bits.
- V  out  N  per-flop violation select; one-hot or zero.
- rD  out  N  per-flop replacement data.
- rV  out  N  per-flop metastable mark.
- grant_idx  out  IW  index of the last granted flop.
- inj_cnt  out  CW  injections completed.
- exhausted  out  1  budget spent.

Behaviour:
- Reset (RS=0, async):
  - state=IDLE.
  - V, rD, rV = 0.
  - grant_idx=0, inj_cnt=0, exhausted=0.
  - Round-robin pointer ptr=0.
- All outputs are registered.
- States:
  - IDLE: leave to ARB when en=1.
  - ARB: if req≠0, grant g = first set bit at or after ptr, searching cyclically. Latch grant_idx=g and hold counter=HOLD_CYC. Next state HOLD. If req=0, stay in ARB.
  - HOLD:
    - V[g]=1, rD[g]=rnd_d[g] and rV[g]=rnd_v[g], all resampled every cycle. All other bits are 0.
    - Decrement the hold counter each cycle.
    - When the counter reaches 0: inj_cnt+=1 and ptr=(g+1) mod N.
    - Then go to EXH if inj_cnt==MAX_INJ; else to COOL if COOL_CYC>0; else to ARB.
  - COOL: V=0 for COOL_CYC cycles, then ARB.
  - EXH: V=0 and exhausted=1. Remains here until clr or en=0.
- Latency: req seen in ARB at edge t gives V[g]=1 from t+1. V deasserts on the edge after the last hold cycle.
- Back-to-back grants with COOL_CYC=0: V is low for exactly one cycle (the ARB cycle) between injections.
- Priority: RS > clr > en=0 > normal operation.
  - clr: next state IDLE. inj_cnt=0, ptr=0, exhausted=0, V/rD/rV=0. grant_idx is kept.
  - en=0 in any state: next state IDLE and V/rD/rV=0. An aborted HOLD does not increment inj_cnt and does not advance ptr. inj_cnt and exhausted are retained; en=0 while in EXH clears exhausted only.
- req changing during HOLD or COOL is ignored; only ARB samples req.
- ptr wraps from N-1 to 0.
- With MAX_INJ=0, the first ARB cycle moves straight to EXH without granting.
- inj_cnt saturates at MAX_INJ; it never wraps.
- Invariants:
  - $onehot0(V) always.
  - rD|rV is a subset of V.
  - exhausted == (state==EXH).

Decomposition:
- Package xprova_inj_pkg holds:
  - state enum {IDLE, ARB, HOLD, COOL, EXH};
  - the clog2 helper function;
  - a shared default-parameter constant.
- Sub-module rr_arbiter (N requesters, ptr in, grant index plus valid out) is combinational. It is reused by later DFFx-bank controllers.

Test Plan (N=4, MAX_INJ=3, HOLD_CYC=2, COOL_CYC=1 unless noted):
1. Reset with RS=0 mid-HOLD -> V, rD, rV, inj_cnt, exhausted all 0 immediately; state IDLE after RS=1.
2. en=1, req=4'b1010 held -> grants 1, 3, 1 in turn. V=0010 for 2 cycles, 0 for 2 cycles (COOL+ARB), then 1000 for 2 cycles, then 0010. inj_cnt counts 1, 2, 3, then exhausted=1 and V stays 0.
3. rnd_d=4'b1111, rnd_v=4'b0000 during a grant to flop 2 -> rD=0100, rV=0000, V=0100; then flip rnd_v to 1111 mid-hold -> rV=0100 on the next cycle.
4. Drop en in the second HOLD cycle -> V=0 next cycle, inj_cnt unchanged, next grant goes to the same index again.
5. In EXH, pulse clr with en=1 -> exhausted=0, inj_cnt=0; with req=0001, the next grant is index 0 (ptr reset).
6. COOL_CYC=0, HOLD_CYC=1, req=4'b1111 -> V sequence 0001, 0000, 0010, 0000, 0100, then EXH; $onehot0(V) holds throughout.
